// File: rtl/basic_io_event_capture.sv
// Basic I/O event capture: per-channel synchroniser and debouncer feeding a
// timestamped snapshot FIFO, triggered on change or at a fixed sample period.
module basic_io_event_capture #(
  parameter int NUM_CH          = 3,
  parameter int CH_WIDTH        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SAMPLE_PERIOD   = 16,
  parameter int TS_WIDTH        = 16,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_CH*CH_WIDTH-1:0]       i_data,
  input  logic [NUM_CH-1:0]                i_ch_mask,
  input  logic                             i_mode,
  input  logic                             i_clear,
  output logic                             o_evt_valid,
  input  logic                             i_evt_ready,
  output logic [NUM_CH*CH_WIDTH-1:0]       o_evt_data,
  output logic [NUM_CH-1:0]                o_evt_changed,
  output logic [TS_WIDTH-1:0]              o_evt_ts,
  output logic [$clog2(FIFO_DEPTH):0]      o_fifo_level,
  output logic                             o_overflow,
  output logic [7:0]                       o_drop_count
);
  localparam int DW  = NUM_CH * CH_WIDTH;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CNW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW  = $clog2(SAMPLE_PERIOD);
  localparam int EW  = DW + NUM_CH + TS_WIDTH;
  localparam logic [CNW-1:0] CNT_LAST = CNW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0]  PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [AW:0]    LVL_FULL = (AW+1)'(FIFO_DEPTH);

  // Stage 0: synchroniser chain, plain flops only
  logic [DW-1:0] sync_q [SYNC_STAGES];
  logic [DW-1:0] sync_v;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= i_data;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_v = sync_q[SYNC_STAGES-1];

  // Stage 1: per-channel debounce, chg pulses the cycle after stable moves
  logic [DW-1:0]     cand;
  logic [DW-1:0]     stable;
  logic [CNW-1:0]    cnt [NUM_CH];
  logic [NUM_CH-1:0] chg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cand   <= '0;
      stable <= '0;
      chg    <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        chg[c] <= 1'b0;
        if (sync_v[c*CH_WIDTH +: CH_WIDTH] != cand[c*CH_WIDTH +: CH_WIDTH]) begin
          cand[c*CH_WIDTH +: CH_WIDTH] <= sync_v[c*CH_WIDTH +: CH_WIDTH];
          cnt[c] <= '0;
        end else if (cand[c*CH_WIDTH +: CH_WIDTH] != stable[c*CH_WIDTH +: CH_WIDTH]) begin
          if (cnt[c] == CNT_LAST) begin
            stable[c*CH_WIDTH +: CH_WIDTH] <= cand[c*CH_WIDTH +: CH_WIDTH];
            chg[c] <= 1'b1;
          end else begin
            cnt[c] <= cnt[c] + 1'b1;
          end
        end
      end
    end
  end

  // Stage 2: event formation (timestamp, period counter, change accumulator)
  logic [TS_WIDTH-1:0] ts;
  logic [PW-1:0]       pcnt;
  logic [NUM_CH-1:0]   acc;
  logic [NUM_CH-1:0]   chg_m;
  logic [NUM_CH-1:0]   evt_chg;
  logic                per_tc;
  logic                wr;
  logic [EW-1:0]       evt;

  assign chg_m   = chg & i_ch_mask;
  assign per_tc  = (pcnt == PER_LAST);
  assign wr      = i_mode ? per_tc : |chg_m;
  assign evt_chg = i_mode ? (acc | chg_m) : chg_m;
  assign evt     = {stable, evt_chg, ts};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ts   <= '0;
      pcnt <= '0;
      acc  <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (!i_mode || per_tc) begin
        pcnt <= '0;
        acc  <= '0;
      end else begin
        pcnt <= pcnt + 1'b1;
        acc  <= acc | chg_m;
      end
    end
  end

  // Stage 3: show-ahead event FIFO with drop accounting
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign full = (level == LVL_FULL);
  assign pop  = o_evt_valid & i_evt_ready;
  assign push = wr & (~full | pop);
  assign drop = wr & full & ~pop;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= evt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A drop in the same cycle as a clear is kept, so no event goes unreported
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (i_clear) begin
      o_overflow   <= drop;
      o_drop_count <= {7'd0, drop};
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (o_drop_count != 8'hFF) o_drop_count <= o_drop_count + 8'd1;
    end
  end

  assign o_evt_valid  = (level != '0);
  assign o_fifo_level = level;
  assign {o_evt_data, o_evt_changed, o_evt_ts} = o_evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_basic_io_event_capture.sv
// Bench for basic_io_event_capture: directed scenarios plus randomized traffic,
// checked against a run-length debounce model and a queue-based event FIFO.
module tb_basic_io_event_capture;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 8;
  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int SP     = 16;
  localparam int TSW    = 16;
  localparam int DEPTH  = 8;
  localparam int DW     = NUM_CH * CH_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   data;
  logic [2:0]      mask;
  logic            mode;
  logic            clear;
  logic            ready;
  logic            o_evt_valid;
  logic [DW-1:0]   o_evt_data;
  logic [2:0]      o_evt_changed;
  logic [TSW-1:0]  o_evt_ts;
  logic [3:0]      o_fifo_level;
  logic            o_overflow;
  logic [7:0]      o_drop_count;
  logic [56:0]     dut_out;

  always #5 clk = ~clk;

  basic_io_event_capture #(
    .NUM_CH(NUM_CH), .CH_WIDTH(CH_W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .SAMPLE_PERIOD(SP), .TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_ch_mask(mask), .i_mode(mode),
    .i_clear(clear), .o_evt_valid(o_evt_valid), .i_evt_ready(ready),
    .o_evt_data(o_evt_data), .o_evt_changed(o_evt_changed), .o_evt_ts(o_evt_ts),
    .o_fifo_level(o_fifo_level), .o_overflow(o_overflow), .o_drop_count(o_drop_count)
  );

  assign dut_out = {o_evt_valid, o_fifo_level, o_overflow, o_drop_count,
                    o_evt_data, o_evt_changed, o_evt_ts};

  int checks = 0;
  int passed = 0;

  // Reference model state
  typedef struct packed {
    logic [DW-1:0]  d;
    logic [2:0]     c;
    logic [TSW-1:0] t;
  } evt_t;

  evt_t           q[$];
  logic [DW-1:0]  m_sync [SYNC];
  logic [DW-1:0]  m_prev;
  int             m_run [NUM_CH];
  logic [DW-1:0]  m_stable;
  logic [2:0]     m_chg;
  logic [TSW-1:0] m_ts;
  int             m_per;
  logic [2:0]     m_acc;
  logic           m_ovf;
  int             m_drop;

  // A channel value is accepted once its synchronised copy has held for
  // DEB+1 consecutive samples and differs from the accepted value.
  task automatic model_edge();
    logic [2:0]    chgm, ec, nchg;
    logic          wr, pop, drop;
    logic [DW-1:0] s;
    logic [CH_W-1:0] v;
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) m_sync[i] = '0;
      for (int c = 0; c < NUM_CH; c++) m_run[c] = 0;
      m_prev = '0; m_stable = '0; m_chg = '0; m_ts = '0;
      m_per = 0; m_acc = '0; m_ovf = 1'b0; m_drop = 0;
      q.delete();
    end else begin
      chgm = m_chg & mask;
      if (mode) begin
        wr = (m_per == SP - 1);
        ec = m_acc | chgm;
      end else begin
        wr = |chgm;
        ec = chgm;
      end
      pop  = (q.size() != 0) && ready;
      drop = wr && (q.size() == DEPTH) && !pop;
      if (pop) void'(q.pop_front());
      if (wr && !drop) q.push_back('{d: m_stable, c: ec, t: m_ts});
      if (clear) begin
        m_ovf  = drop;
        m_drop = drop ? 1 : 0;
      end else if (drop) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      if (!mode || wr) begin
        m_per = 0;
        m_acc = '0;
      end else begin
        m_per++;
        m_acc = m_acc | chgm;
      end
      m_ts = m_ts + 16'd1;
      s = m_sync[SYNC-1];
      nchg = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        v = s[c*CH_W +: CH_W];
        if (v == m_prev[c*CH_W +: CH_W]) m_run[c]++;
        else m_run[c] = 1;
        if (m_run[c] >= DEB + 1 && v != m_stable[c*CH_W +: CH_W]) begin
          m_stable[c*CH_W +: CH_W] = v;
          nchg[c] = 1'b1;
        end
      end
      m_prev = s;
      m_chg  = nchg;
      for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = data;
    end
  endtask

  function automatic logic [56:0] exp_out();
    evt_t h;
    h = '0;
    if (q.size() != 0) h = q[0];
    return {q.size() != 0, 4'(q.size()), m_ovf, 8'(m_drop), h.d, h.c, h.t};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data = '0; mask = 3'b111; mode = 1'b0; clear = 1'b0; ready = 1'b0;
    tick(); tick();
    checks++;
    if (dut_out !== 57'd0) $display("FAIL reset_outputs got=%h exp=0", dut_out);
    else passed++;
    checks++;
    if (dut_out !== exp_out()) $display("FAIL reset_model got=%h exp=%h", dut_out, exp_out());
    else passed++;
  endtask

  task automatic test_latency();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    data = 24'h00A500;
    for (int e = 0; e < 7; e++) begin
      tick();
      checks++;
      if (o_evt_valid !== 1'b0) $display("FAIL latency_early edge=%0d valid=%b exp=0", e, o_evt_valid);
      else passed++;
    end
    tick();
    checks++;
    if (o_evt_valid !== 1'b1) $display("FAIL latency_valid got=%b exp=1", o_evt_valid);
    else passed++;
    checks++;
    if (o_evt_data !== 24'h00A500) $display("FAIL latency_data got=%h exp=00a500", o_evt_data);
    else passed++;
    checks++;
    if (o_evt_changed !== 3'b010) $display("FAIL latency_changed got=%b exp=010", o_evt_changed);
    else passed++;
    checks++;
    if (o_evt_ts !== 16'd7) $display("FAIL latency_ts got=%0d exp=7", o_evt_ts);
    else passed++;
    checks++;
    if (dut_out !== exp_out()) $display("FAIL latency_model got=%h exp=%h", dut_out, exp_out());
    else passed++;
  endtask

  task automatic test_glitch();
    ready = 1'b1;
    tick();
    for (int i = 0; i < 18; i++) begin
      data = (i < 3) ? 24'h00A501 : 24'h00A500;
      tick();
      checks++;
      if (o_evt_valid !== 1'b0 || o_fifo_level !== 4'd0)
        $display("FAIL glitch_no_event cyc=%0d valid=%b level=%0d exp 0/0", i, o_evt_valid, o_fifo_level);
      else passed++;
    end
    checks++;
    if (dut_out !== exp_out()) $display("FAIL glitch_model got=%h exp=%h", dut_out, exp_out());
    else passed++;
  endtask

  task automatic test_mask();
    int w;
    mask = 3'b011;
    data = 24'h3CA500;
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++;
      if (o_evt_valid !== 1'b0) $display("FAIL mask_blocked cyc=%0d valid=%b exp=0", i, o_evt_valid);
      else passed++;
    end
    ready = 1'b0;
    data = 24'h3CA55A;
    w = 0;
    while (o_evt_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    checks++;
    if (o_evt_valid !== 1'b1) $display("FAIL mask_evt_timeout valid=%b exp=1", o_evt_valid);
    else passed++;
    checks++;
    if (o_evt_data !== 24'h3CA55A) $display("FAIL mask_data got=%h exp=3ca55a", o_evt_data);
    else passed++;
    checks++;
    if (o_evt_changed !== 3'b001) $display("FAIL mask_changed got=%b exp=001", o_evt_changed);
    else passed++;
    checks++;
    if (dut_out !== exp_out()) $display("FAIL mask_model got=%h exp=%h", dut_out, exp_out());
    else passed++;
  endtask

  task automatic test_periodic();
    int n;
    logic [TSW-1:0] last_ts;
    ready = 1'b1;
    mask = 3'b111;
    tick();
    mode = 1'b1;
    data = 24'h3CA511;
    n = 0;
    last_ts = '0;
    for (int i = 0; i < 60; i++) begin
      tick();
      checks++;
      if (dut_out !== exp_out()) $display("FAIL periodic_model cyc=%0d got=%h exp=%h", i, dut_out, exp_out());
      else passed++;
      if (o_evt_valid === 1'b1) begin
        n++;
        checks++;
        if (n == 1) begin
          if (o_evt_changed !== 3'b001) $display("FAIL periodic_first_chg got=%b exp=001", o_evt_changed);
          else passed++;
        end else begin
          if (o_evt_changed !== 3'b000 || 16'(o_evt_ts - last_ts) !== 16'(SP))
            $display("FAIL periodic_next n=%0d chg=%b dts=%0d exp chg=000 dts=%0d",
                     n, o_evt_changed, 16'(o_evt_ts - last_ts), SP);
          else passed++;
        end
        last_ts = o_evt_ts;
      end
    end
    checks++;
    if (n < 3) $display("FAIL periodic_count got=%0d exp>=3", n);
    else passed++;
    mode = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    tick(); tick();
    ready = 1'b0;
    v = data[23:16];
    for (int k = 0; k < 10; k++) begin
      v = v ^ 8'(1 + $urandom_range(0, 254));
      data[23:16] = v;
      repeat (8) tick();
    end
    repeat (10) tick();
    checks++;
    if (o_fifo_level !== 4'd8 || o_overflow !== 1'b1 || o_drop_count !== 8'd2)
      $display("FAIL overflow_state level=%0d ovf=%b drops=%0d exp 8/1/2", o_fifo_level, o_overflow, o_drop_count);
    else passed++;
    checks++;
    if (dut_out !== exp_out()) $display("FAIL overflow_model got=%h exp=%h", dut_out, exp_out());
    else passed++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (o_fifo_level !== 4'd8 || o_overflow !== 1'b0 || o_drop_count !== 8'd0)
      $display("FAIL clear_state level=%0d ovf=%b drops=%0d exp 8/0/0", o_fifo_level, o_overflow, o_drop_count);
    else passed++;
  endtask

  task automatic test_full_pop();
    int w;
    data[15:8] = data[15:8] ^ 8'hFF;
    w = 0;
    while ((m_chg & mask) == 3'b000 && w < 20) begin
      tick();
      w++;
    end
    checks++;
    if ((m_chg & mask) == 3'b000) $display("FAIL fullpop_timeout waited=%0d exp<20", w);
    else passed++;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (o_fifo_level !== 4'd8 || o_overflow !== 1'b0 || o_drop_count !== 8'd0)
      $display("FAIL fullpop_state level=%0d ovf=%b drops=%0d exp 8/0/0", o_fifo_level, o_overflow, o_drop_count);
    else passed++;
    checks++;
    if (dut_out !== exp_out()) $display("FAIL fullpop_model got=%h exp=%h", dut_out, exp_out());
    else passed++;
    // Drop in the same cycle as a clear
    data[7:0] = data[7:0] ^ 8'h81;
    w = 0;
    while ((m_chg & mask) == 3'b000 && w < 20) begin
      tick();
      w++;
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (o_overflow !== 1'b1 || o_drop_count !== 8'd1 || o_fifo_level !== 4'd8)
      $display("FAIL clear_drop ovf=%b drops=%0d level=%0d exp 1/1/8", o_overflow, o_drop_count, o_fifo_level);
    else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (o_evt_valid !== 1'b0 || o_fifo_level !== 4'd0 || o_overflow !== 1'b0 || o_drop_count !== 8'd0)
      $display("FAIL midreset valid=%b level=%0d ovf=%b drops=%0d exp 0/0/0/0",
               o_evt_valid, o_fifo_level, o_overflow, o_drop_count);
    else passed++;
  endtask

  task automatic test_random();
    int pct;
    for (int i = 0; i < 800; i++) begin
      pct = ((i / 100) % 2) ? 90 : 15;
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 5) == 0) data[c*CH_W +: CH_W] = 8'($urandom);
      ready = ($urandom_range(0, 99) < pct);
      clear = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 59) == 0) mode = ~mode;
      if ($urandom_range(0, 39) == 0) mask = 3'($urandom);
      tick();
      checks++;
      if (dut_out !== exp_out()) $display("FAIL random_model cyc=%0d got=%h exp=%h", i, dut_out, exp_out());
      else passed++;
    end
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_mask();
    test_periodic();
    test_overflow();
    test_full_pop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
